// File: rtl/riscv_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_dmem_arbiter
//
// Shares the single-port data memory between the core load/store path
// (port C) and a DMA/debug loader (port D). Grants are combinational and
// round-robin. Granted accesses drive the word address, byte strobes and
// lane-shifted store data. Loads return lane-aligned, sign- or zero-extended
// data one cycle after the grant.
//
// Ports
//   i_clk, i_rstn            clock, asynchronous active-low reset
//   i_x_req/wr/addr/size     request from port x (x = c, d); fields held
//   i_x_unsigned/wdata         stable until o_x_gnt
//   o_x_gnt                  combinational grant
//   o_x_rvalid/rdata/err     one-cycle load completion (or error) response
//   o_dmem_addr/byte_sel     word address and byte strobes to memory
//   o_dmem_data/wr_en        lane-shifted store data and write enable
//   i_dmem_data              memory read word (combinational from address)
// ---------------------------------------------------------------------------
module riscv_dmem_arbiter #(
    parameter int XLEN          = 32,
    parameter int DMEM_ADDR_BIT = 12
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,

    input  logic                     i_c_req,
    input  logic                     i_c_wr,
    input  logic [DMEM_ADDR_BIT-1:0] i_c_addr,
    input  logic [1:0]               i_c_size,
    input  logic                     i_c_unsigned,
    input  logic [XLEN-1:0]          i_c_wdata,
    output logic                     o_c_gnt,
    output logic                     o_c_rvalid,
    output logic [XLEN-1:0]          o_c_rdata,
    output logic                     o_c_err,

    input  logic                     i_d_req,
    input  logic                     i_d_wr,
    input  logic [DMEM_ADDR_BIT-1:0] i_d_addr,
    input  logic [1:0]               i_d_size,
    input  logic                     i_d_unsigned,
    input  logic [XLEN-1:0]          i_d_wdata,
    output logic                     o_d_gnt,
    output logic                     o_d_rvalid,
    output logic [XLEN-1:0]          o_d_rdata,
    output logic                     o_d_err,

    output logic [XLEN-1:0]          o_dmem_data,
    input  logic [XLEN-1:0]          i_dmem_data,
    output logic [DMEM_ADDR_BIT-3:0] o_dmem_addr,
    output logic [3:0]               o_dmem_byte_sel,
    output logic                     o_dmem_wr_en
);

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    // State captured at the grant edge of a load or errored access.
    typedef struct packed {
        logic            valid;
        port_e           port;
        logic            err;
        logic [1:0]      off;
        logic [1:0]      size;
        logic            uns;
        logic [XLEN-1:0] word;
    } pend_t;

    port_e last_q;
    pend_t pend_q;

    logic                     any_gnt;
    logic                     sel_wr;
    logic [DMEM_ADDR_BIT-1:0] sel_addr;
    logic [1:0]               sel_size;
    logic                     sel_uns;
    logic [XLEN-1:0]          sel_wdata;
    logic [1:0]               sel_off;
    logic                     sel_err;
    logic [3:0]               strobe;

    // ---------------------------------------------------------------------
    // Arbitration: a lone requester always wins; on contention the port that
    // was not granted last wins. Reset masks every grant.
    // ---------------------------------------------------------------------
    assign o_c_gnt = i_rstn & i_c_req & (~i_d_req | (last_q == PORT_D));
    assign o_d_gnt = i_rstn & i_d_req & (~i_c_req | (last_q == PORT_C));
    assign any_gnt = o_c_gnt | o_d_gnt;

    // Field mux follows C unless D is granted, so the idle memory side
    // simply reflects port C.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        sel_wr    = i_c_wr;
        sel_addr  = i_c_addr;
        sel_size  = i_c_size;
        sel_uns   = i_c_unsigned;
        sel_wdata = i_c_wdata;
        if (o_d_gnt) begin
            sel_wr    = i_d_wr;
            sel_addr  = i_d_addr;
            sel_size  = i_d_size;
            sel_uns   = i_d_unsigned;
            sel_wdata = i_d_wdata;
        end
    end

    assign sel_off = sel_addr[1:0];

    always_comb begin
        sel_err = 1'b1;
        strobe  = 4'b0000;
        case (sel_size)
            SIZE_BYTE: begin
                sel_err = 1'b0;
                strobe  = 4'b0001 << sel_off;
            end
            SIZE_HALF: begin
                sel_err = sel_off[0];
                strobe  = 4'b0011 << sel_off;
            end
            SIZE_WORD: begin
                sel_err = |sel_off;
                strobe  = 4'b1111;
            end
            default: begin
                sel_err = 1'b1;
                strobe  = 4'b0000;
            end
        endcase
    end

    assign o_dmem_addr     = sel_addr[DMEM_ADDR_BIT-1:2];
    assign o_dmem_data     = sel_wdata << {sel_off, 3'b000};
    assign o_dmem_byte_sel = (any_gnt & ~sel_err) ? strobe : 4'b0000;
    assign o_dmem_wr_en    = any_gnt & sel_wr & ~sel_err;

    // ---------------------------------------------------------------------
    // Round-robin pointer and pending-response register.
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            last_q <= PORT_D;
            // NOTE: the captured read word is an ordinary register, not a
            // memory array, so it is reset along with the rest of the state.
            pend_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            if (any_gnt) begin
                last_q      <= o_d_gnt ? PORT_D : PORT_C;
                pend_q.port <= o_d_gnt ? PORT_D : PORT_C;
                pend_q.err  <= sel_err;
                pend_q.off  <= sel_off;
                pend_q.size <= sel_size;
                pend_q.uns  <= sel_uns;
                pend_q.word <= i_dmem_data;
            end
            // Stores retire at the grant edge; only loads and errors respond.
            pend_q.valid <= any_gnt & (~sel_wr | sel_err);
        end
    end

    // ---------------------------------------------------------------------
    // Load response: align the addressed lane to bit 0, then extend.
    // ---------------------------------------------------------------------
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ext_data;

    assign shifted = pend_q.word >> {pend_q.off, 3'b000};

    always_comb begin
        ext_data = shifted;
        case (pend_q.size)
            SIZE_BYTE: ext_data = pend_q.uns ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                             : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            SIZE_HALF: ext_data = pend_q.uns ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                             : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            default:   ext_data = shifted;
        endcase
        if (pend_q.err) begin
            ext_data = '0;
        end
    end

    assign o_c_rvalid = pend_q.valid & (pend_q.port == PORT_C);
    assign o_d_rvalid = pend_q.valid & (pend_q.port == PORT_D);
    assign o_c_err    = o_c_rvalid & pend_q.err;
    assign o_d_err    = o_d_rvalid & pend_q.err;
    assign o_c_rdata  = o_c_rvalid ? ext_data : '0;
    assign o_d_rdata  = o_d_rvalid ? ext_data : '0;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_riscv_dmem_arbiter
//
// Directed bench for riscv_dmem_arbiter with a byte-enabled memory model.
// Stimulus checks grant/strobe/write-data in the grant cycle and pushes the
// expected response; a monitor pops and compares on every rvalid.
// ---------------------------------------------------------------------------
module tb_riscv_dmem_arbiter;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        c_req, c_wr, c_uns, c_gnt, c_rvalid, c_err;
    logic [11:0] c_addr;
    logic [1:0]  c_size;
    logic [31:0] c_wdata, c_rdata;
    logic        d_req, d_wr, d_uns, d_gnt, d_rvalid, d_err;
    logic [11:0] d_addr;
    logic [1:0]  d_size;
    logic [31:0] d_wdata, d_rdata;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic [9:0]  dmem_addr;
    logic [3:0]  dmem_byte_sel;
    logic        dmem_wr_en;

    riscv_dmem_arbiter #(.XLEN(32), .DMEM_ADDR_BIT(12)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_c_req(c_req), .i_c_wr(c_wr), .i_c_addr(c_addr), .i_c_size(c_size),
        .i_c_unsigned(c_uns), .i_c_wdata(c_wdata), .o_c_gnt(c_gnt),
        .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata), .o_c_err(c_err),
        .i_d_req(d_req), .i_d_wr(d_wr), .i_d_addr(d_addr), .i_d_size(d_size),
        .i_d_unsigned(d_uns), .i_d_wdata(d_wdata), .o_d_gnt(d_gnt),
        .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata), .o_d_err(d_err),
        .o_dmem_data(dmem_wdata), .i_dmem_data(dmem_rdata),
        .o_dmem_addr(dmem_addr), .o_dmem_byte_sel(dmem_byte_sel),
        .o_dmem_wr_en(dmem_wr_en)
    );

    // Memory model: combinational read, byte-enabled write at the edge.
    logic [31:0] mem [0:1023];
    assign dmem_rdata = mem[dmem_addr];
    always @(posedge clk) begin
        if (dmem_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_byte_sel[b]) mem[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
            end
        end
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    endtask

    typedef struct {
        bit          port;
        logic [31:0] data;
        bit          err;
        int          due;
    } exp_t;
    exp_t sb[$];

    task automatic push(input bit port, input logic [31:0] data, input bit err, input int due);
        exp_t e;
        e.port = port; e.data = data; e.err = err; e.due = due;
        sb.push_back(e);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (c_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
                check("unexpected_rvalid", 32'({c_rvalid, d_rvalid}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("rvalid_port", 32'({c_rvalid, d_rvalid}), e.port ? 32'd1 : 32'd2);
                check("rdata", e.port ? d_rdata : c_rdata, e.data);
                check("err", 32'(e.port ? d_err : c_err), 32'(e.err));
                check("rvalid_cycle", 32'(cycle), 32'(e.due));
            end
        end else if (sb.size() > 0 && sb[0].due <= cycle) begin
            e = sb.pop_front();
            check("missing_rvalid", 32'({c_rvalid, d_rvalid}), e.port ? 32'd1 : 32'd2);
        end
    end

    // One single-port access; the other port is idle. exp_val is the
    // lane-shifted write data for stores, the extended result for loads.
    task automatic access(input bit pd, input bit wr, input logic [11:0] addr,
                          input logic [1:0] size, input bit uns, input logic [31:0] wdata,
                          input logic [3:0] exp_bsel, input bit exp_err,
                          input logic [31:0] exp_val);
        @(posedge clk); #1;
        c_req = 1'b0;
        d_req = 1'b0;
        if (pd) begin
            d_req = 1'b1; d_wr = wr; d_addr = addr; d_size = size; d_uns = uns; d_wdata = wdata;
        end else begin
            c_req = 1'b1; c_wr = wr; c_addr = addr; c_size = size; c_uns = uns; c_wdata = wdata;
        end
        @(negedge clk);
        check("gnt", 32'(pd ? d_gnt : c_gnt), 32'd1);
        check("other_gnt", 32'(pd ? c_gnt : d_gnt), 32'd0);
        check("byte_sel", 32'(dmem_byte_sel), 32'(exp_bsel));
        check("wr_en", 32'(dmem_wr_en), 32'(wr & ~exp_err));
        check("dmem_addr", 32'(dmem_addr), 32'(addr[11:2]));
        if (wr && !exp_err) check("dmem_data", dmem_wdata, exp_val);
        if (!wr || exp_err) push(pd, exp_err ? 32'd0 : exp_val, exp_err, cycle + 1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        c_req = 1'b0;
        d_req = 1'b0;
    endtask

    // Both ports load word 0 (C) and word 1 (D).
    task automatic set_both_loads();
        c_req = 1'b1; c_wr = 1'b0; c_addr = 12'h000; c_size = SZ_W; c_uns = 1'b0;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 12'h004; d_size = SZ_W; d_uns = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        rstn = 1'b0;
        c_req = 0; c_wr = 0; c_addr = 0; c_size = 0; c_uns = 0; c_wdata = 0;
        d_req = 0; d_wr = 0; d_addr = 0; d_size = 0; d_uns = 0; d_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        // Requests during reset must not be granted.
        c_req = 1'b1; c_wr = 1'b1; d_req = 1'b1;
        #1;
        check("rst_c_gnt", 32'(c_gnt), 32'd0);
        check("rst_d_gnt", 32'(d_gnt), 32'd0);
        check("rst_wr_en", 32'(dmem_wr_en), 32'd0);
        check("rst_rvalid", 32'({c_rvalid, d_rvalid}), 32'd0);
        check("rst_err", 32'({c_err, d_err}), 32'd0);
        check("rst_c_rdata", c_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        c_req = 1'b0; c_wr = 1'b0; d_req = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        // Word 0 <- 0x80F1_7F02, then sign/zero extension loads.
        access(0, 1, 12'h000, SZ_W, 0, 32'h80F1_7F02, 4'b1111, 0, 32'h80F1_7F02);
        access(0, 0, 12'h001, SZ_B, 0, 32'h0,         4'b0010, 0, 32'h0000_007F);
        access(0, 0, 12'h002, SZ_H, 0, 32'h0,         4'b1100, 0, 32'hFFFF_80F1);
        access(0, 0, 12'h002, SZ_H, 1, 32'h0,         4'b1100, 0, 32'h0000_80F1);
        access(1, 0, 12'h003, SZ_B, 0, 32'h0,         4'b1000, 0, 32'hFFFF_FF80);
        access(0, 0, 12'h000, SZ_W, 1, 32'h0,         4'b1111, 0, 32'h80F1_7F02);

        // Byte store over 0x1122_3344, reloaded the next cycle.
        access(0, 1, 12'h000, SZ_W, 0, 32'h1122_3344, 4'b1111, 0, 32'h1122_3344);
        access(0, 1, 12'h003, SZ_B, 0, 32'h0000_00AA, 4'b1000, 0, 32'hAA00_0000);
        access(0, 0, 12'h000, SZ_W, 0, 32'h0,         4'b1111, 0, 32'hAA22_3344);

        // Port D traffic on word 1; leaves last = D.
        access(1, 1, 12'h004, SZ_W, 0, 32'h5566_7788, 4'b1111, 0, 32'h5566_7788);
        access(1, 1, 12'h006, SZ_H, 0, 32'h0000_BEEF, 4'b1100, 0, 32'hBEEF_0000);
        access(1, 0, 12'h004, SZ_W, 0, 32'h0,         4'b1111, 0, 32'hBEEF_7788);
        access(1, 0, 12'h006, SZ_H, 0, 32'h0,         4'b1100, 0, 32'hFFFF_BEEF);
        access(1, 0, 12'h007, SZ_B, 1, 32'h0,         4'b1000, 0, 32'h0000_00BE);

        // Contention for 6 cycles: C,D,C,D,C,D.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            set_both_loads();
            @(negedge clk);
            check("rr_c_gnt", 32'(c_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_d_gnt", 32'(d_gnt), (i % 2 == 0) ? 32'd0 : 32'd1);
            if (i % 2 == 0) push(0, 32'hAA22_3344, 0, cycle + 1);
            else            push(1, 32'hBEEF_7788, 0, cycle + 1);
        end
        // Only D requesting: granted every cycle.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            set_both_loads();
            c_req = 1'b0;
            @(negedge clk);
            check("donly_d_gnt", 32'(d_gnt), 32'd1);
            check("donly_c_gnt", 32'(c_gnt), 32'd0);
            push(1, 32'hBEEF_7788, 0, cycle + 1);
        end

        // Misaligned and reserved-size accesses.
        access(0, 1, 12'h002, SZ_W, 0, 32'hDEAD_BEEF, 4'b0000, 1, 32'h0);
        access(0, 0, 12'h001, SZ_H, 0, 32'h0,         4'b0000, 1, 32'h0);
        access(1, 0, 12'h000, SZ_R, 0, 32'h0,         4'b0000, 1, 32'h0);
        idle();
        check("mem_unchanged", mem[0], 32'hAA22_3344);
        access(0, 0, 12'h000, SZ_W, 0, 32'h0,         4'b1111, 0, 32'hAA22_3344);
        idle();
        idle();

        // Reset asserted in the cycle after a load grant.
        @(posedge clk); #1;
        c_req = 1'b1; c_wr = 1'b0; c_addr = 12'h000; c_size = SZ_W;
        @(negedge clk);
        check("pre_rst_c_gnt", 32'(c_gnt), 32'd1);
        @(posedge clk); #1;
        rstn = 1'b0;
        set_both_loads();
        #1;
        check("midrst_rvalid", 32'({c_rvalid, d_rvalid}), 32'd0);
        check("midrst_c_rdata", c_rdata, 32'd0);
        check("midrst_err", 32'({c_err, d_err}), 32'd0);
        check("midrst_gnt", 32'({c_gnt, d_gnt}), 32'd0);
        check("midrst_wr_en", 32'(dmem_wr_en), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_c_first", 32'({c_gnt, d_gnt}), 32'd2);
        push(0, 32'hAA22_3344, 0, cycle + 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_d_second", 32'({c_gnt, d_gnt}), 32'd1);
        push(1, 32'hBEEF_7788, 0, cycle + 1);
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/riscv_dmem_arbiter.md
# riscv_dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port `riscv_dmem`. It shares the data memory between the core load/store path (port C) and a DMA/debug loader (port D) with round-robin priority. For each granted request it generates the word address, byte strobes and lane-shifted write data. For reads it returns lane-aligned, sign- or zero-extended data one cycle later.

## Interface
Parameters:
- `XLEN`, 32, data width; fixed at 32 for this block.
- `DMEM_ADDR_BIT`, 12, byte-address width; memory word address is `DMEM_ADDR_BIT-2` bits.

Ports. `x` is `c` or `d`; each port group exists once per requester.
- Clock and reset: one clock; reset is asynchronous and active-low (`i_clk`, `i_rstn`).
- `i_clk` in 1: clock.
- `i_rstn` in 1: asynchronous active-low reset.
- `i_x_req` in 1: request. Held with all request fields stable until `o_x_gnt`.
- `i_x_wr` in 1: 1 means store, 0 means load.
- `i_x_addr` in `DMEM_ADDR_BIT`: byte address.
- `i_x_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `i_x_unsigned` in 1: load zero-extends when 1, sign-extends when 0.
- `i_x_wdata` in `XLEN`: store data, right-justified.
- `o_x_gnt` out 1: combinational grant, same cycle as request.
- `o_x_rvalid` out 1: one-cycle pulse, completion of a granted load or of an errored access.
- `o_x_rdata` out `XLEN`: extended load data; valid when `o_x_rvalid`.
- `o_x_err` out 1: qualifies `o_x_rvalid`; set for a misaligned access or size 11.
- `o_dmem_data` out `XLEN`: lane-shifted write data.
- `i_dmem_data` in `XLEN`: memory read word (combinational from address).
- `o_dmem_addr` out `DMEM_ADDR_BIT-2`: word address, `addr[DMEM_ADDR_BIT-1:2]`.
- `o_dmem_byte_sel` out 4: byte strobes.
- `o_dmem_wr_en` out 1: write enable.

## Operation
- **Arbitration.** Each cycle at most one grant.
  - If only one port requests, that port is granted.
  - If both request, the port other than `last` is granted.
  - `last` is a one-bit register. It updates to the granted port at each grant and resets to D, so C wins the first contention.
- **Misalignment.**
  - Half access with `addr[0]`=1 is misaligned.
  - Word access with `addr[1:0]`≠0 is misaligned.
  - Size 11 is an error.
  - An errored access is still granted, which counts for round-robin. It does not assert `o_dmem_wr_en`, forces byte_sel 0, and completes with `rvalid=1`, `err=1`, `rdata=0`.
- **Byte strobes.**
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `4'b0011 << addr[1:0]`.
  - Word: `4'b1111`.
  - The strobes drive `o_dmem_byte_sel` for both reads and writes.
- **Write data.** `o_dmem_data = wdata << (8*addr[1:0])`.
- **Write enable.** `o_dmem_wr_en = gnt & wr & ~err`.
- **Load path.**
  - On the grant cycle, register the granted port id, `addr[1:0]`, size, unsigned flag and `i_dmem_data`.
  - Next cycle: shift right by `8*addr[1:0]`, then zero-extend or sign-extend from bit 7 (byte) or bit 15 (half).
  - Stores produce no `rvalid`. They complete at the grant edge.
- **Idle memory side.** With no grant: `wr_en=0`, `byte_sel=0`; `addr` and `data` follow port C fields (don't-care).
- **Reset.** While `i_rstn`=0, all grants and `o_dmem_wr_en` are forced 0 combinationally.

## Timing
- Cycle N: `req` and `gnt` high. A store commits to memory at the rising edge ending N.
- Load: `o_x_rvalid` and `o_x_rdata` are valid in N+1 for exactly one cycle.
- Throughput: one access per cycle.
  - Back-to-back loads from the same port are allowed; `rvalid` pulses in consecutive cycles.
- Store at N followed by a load of the same word at N+1, from either port: the load returns the new data.
- A requester keeping `req` high after `gnt` issues a new access in the next cycle.
- Reset values: `last`=D; `o_c_rvalid`, `o_d_rvalid`, `o_c_err`, `o_d_err`=0; `o_c_rdata`, `o_d_rdata`=0; pending load state cleared.
- Reset asserted in N+1 after a load grant at N: no `rvalid` is produced for that load.
- Reset deasserted: arbitration resumes on the first edge after release. C wins the first contention.

## Test plan
- **Sign/zero extension.** Memory word `0x80F1_7F02` at word 0.
  - C loads byte signed at addr 1 → `rdata=0xFFFF_FF7F`? No: lane 1 is `0x7F`, giving `0x0000_007F`.
  - C loads half signed at addr 2 → `0xFFFF_80F1`.
  - C loads half unsigned at addr 2 → `0x0000_80F1`.
  - Each result has `rvalid` exactly at N+1.
- **Byte store.** C stores byte `0xAA` at addr 3 over `0x1122_3344`.
  - Required: `byte_sel=1000`, `o_dmem_data[31:24]=0xAA`.
  - A reload of the word gives `0xAA22_3344` in the next cycle.
- **Contention.** C and D request continuously for 6 cycles.
  - Grants must be C,D,C,D,C,D.
  - With only D requesting, D is granted every cycle.
- **Misaligned word.** Word store at addr 2.
  - Required: `gnt=1`, `wr_en=0`.
  - Next cycle: `rvalid=1`, `err=1`.
  - Memory is unchanged.
  - A half load at addr 1 also gives `err=1`.
- **Reset mid-load.** Assert `i_rstn`=0 mid-cycle after a load grant.
  - Required: no `rvalid`, outputs are at their reset values, `last`=D.
  - After release, simultaneous requests grant C first.
